// File: rtl/retire_trace_pkg.sv
// Shared types and defaults for the retire trace buffer.
//   trace_entry_t : one retired-instruction record at the default datapath width
//   trace_state_e : RUN (accepting), HALTED (draining), DRAINED (terminal)
package retire_trace_pkg;

  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_XLEN  = 32;

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] pc;
    logic [DEFAULT_XLEN-1:0] next_pc;
    logic [DEFAULT_XLEN-1:0] instr;
    logic [4:0]              rd;
    logic                    rd_we;
    logic [DEFAULT_XLEN-1:0] rd_data;
  } trace_entry_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALTED  = 2'd1,
    DRAINED = 2'd2
  } trace_state_e;

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead FIFO of trace entries.
//   clk, rst          : clock, synchronous active-high reset (control only)
//   push, pop         : write tail / retire head; both may be set in one cycle,
//                       including when full (the caller guarantees pop implies !empty)
//   wr_entry          : entry written at the tail on push
//   rd_entry          : head entry, forced to zero while empty
//   count, full, empty: occupancy status
module trace_fifo
  import retire_trace_pkg::*;
#(
  parameter int  DEPTH   = DEFAULT_DEPTH,
  parameter type entry_t = trace_entry_t,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  entry_t  wr_entry,
  output entry_t  rd_entry,
  output logic [AW:0] count,
  output logic    full,
  output logic    empty
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  // Pointers are exactly AW bits, so the +1 wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; only the read path is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_entry;
  end

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign rd_entry = empty ? '0 : mem[rptr];

endmodule

// File: rtl/retire_trace_buffer.sv
// Retirement trace buffer: captures each instruction retiring from WB into a
// FIFO that a trace consumer drains with a valid/ready handshake.
//   clk, rst                 : clock, synchronous active-high reset
//   wb_*                     : retiring instruction (pc, next pc, word, rd write)
//   halt                     : CPU halt pulse; stops capture after this cycle
//   trc_valid/trc_ready      : head handshake; trc_* carry the head entry
//   count                    : occupancy
//   overflow                 : sticky, an entry was dropped because the FIFO was full
//   retire_count             : entries accepted since reset (wraps)
//   drained                  : halted and every captured entry consumed
module retire_trace_buffer
  import retire_trace_pkg::*;
#(
  parameter int  DEPTH = DEFAULT_DEPTH,
  parameter int  XLEN  = DEFAULT_XLEN,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [XLEN-1:0] wb_next_pc,
  input  logic [XLEN-1:0] wb_instr,
  input  logic [4:0]      wb_rd,
  input  logic            wb_rd_we,
  input  logic [XLEN-1:0] wb_rd_data,
  input  logic            halt,
  output logic            trc_valid,
  input  logic            trc_ready,
  output logic [XLEN-1:0] trc_pc,
  output logic [XLEN-1:0] trc_next_pc,
  output logic [XLEN-1:0] trc_instr,
  output logic [4:0]      trc_rd,
  output logic            trc_rd_we,
  output logic [XLEN-1:0] trc_rd_data,
  output logic [AW:0]     count,
  output logic            overflow,
  output logic [31:0]     retire_count,
  output logic            drained
);

  // Same layout as trace_entry_t, sized by this instance's XLEN.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      rd;
    logic            rd_we;
    logic [XLEN-1:0] rd_data;
  } entry_t;

  trace_state_e state_q, state_d;
  entry_t       wr_entry, head;
  logic         push, pop, full, empty, in_run;

  assign in_run    = (state_q == RUN);
  assign trc_valid = !empty;
  assign pop       = trc_valid && trc_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push      = wb_valid && in_run && (!full || pop);

  // Writes to x0 are architecturally invisible, so they are traced as no-writes.
  always_comb begin
    wr_entry.pc      = wb_pc;
    wr_entry.next_pc = wb_next_pc;
    wr_entry.instr   = wb_instr;
    wr_entry.rd      = wb_rd;
    wr_entry.rd_we   = wb_rd_we;
    wr_entry.rd_data = wb_rd_data;
    if (wb_rd == 5'd0) begin
      wr_entry.rd_we   = 1'b0;
      wr_entry.rd_data = '0;
    end
  end

  trace_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .wr_entry (wr_entry),
    .rd_entry (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // ---- control registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      overflow     <= 1'b0;
      retire_count <= '0;
    end else begin
      state_q <= state_d;
      if (wb_valid && in_run && full && !pop) overflow <= 1'b1;
      if (push) retire_count <= retire_count + 32'd1;
    end
  end

  // The last pop and the HALTED->DRAINED step share an edge, so drained rises
  // together with count reaching zero.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt) state_d = HALTED;
      HALTED:  if (empty || (count == (AW+1)'(1) && pop)) state_d = DRAINED;
      DRAINED: state_d = DRAINED;
      default: state_d = RUN;
    endcase
  end

  assign drained     = (state_q == DRAINED);
  assign trc_pc      = head.pc;
  assign trc_next_pc = head.next_pc;
  assign trc_instr   = head.instr;
  assign trc_rd      = head.rd;
  assign trc_rd_we   = head.rd_we;
  assign trc_rd_data = head.rd_data;

endmodule

// File: tb/tb_retire_trace_buffer.sv
module tb_retire_trace_buffer;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  logic            clk;
  logic            rst;
  logic            wb_valid;
  logic [XLEN-1:0] wb_pc, wb_next_pc, wb_instr, wb_rd_data;
  logic [4:0]      wb_rd;
  logic            wb_rd_we;
  logic            halt;
  logic            trc_valid;
  logic            trc_ready;
  logic [XLEN-1:0] trc_pc, trc_next_pc, trc_instr, trc_rd_data;
  logic [4:0]      trc_rd;
  logic            trc_rd_we;
  logic [3:0]      count;
  logic            overflow;
  logic [31:0]     retire_count;
  logic            drained;

  retire_trace_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_pc        (wb_pc),
    .wb_next_pc   (wb_next_pc),
    .wb_instr     (wb_instr),
    .wb_rd        (wb_rd),
    .wb_rd_we     (wb_rd_we),
    .wb_rd_data   (wb_rd_data),
    .halt         (halt),
    .trc_valid    (trc_valid),
    .trc_ready    (trc_ready),
    .trc_pc       (trc_pc),
    .trc_next_pc  (trc_next_pc),
    .trc_instr    (trc_instr),
    .trc_rd       (trc_rd),
    .trc_rd_we    (trc_rd_we),
    .trc_rd_data  (trc_rd_data),
    .count        (count),
    .overflow     (overflow),
    .retire_count (retire_count),
    .drained      (drained)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain queue of records plus a mode number
  // (0 = capturing, 1 = halted, 2 = drained).
  typedef struct {
    logic [31:0] pc, npc, instr;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } rec_t;

  rec_t        q[$];
  int          mode;
  bit          m_ovf;
  logic [31:0] m_rc;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_edge();
    int  sz;
    bit  do_pop, do_push;
    rec_t r;
    if (rst) begin
      q.delete();
      mode  = 0;
      m_ovf = 0;
      m_rc  = 0;
      return;
    end
    sz      = q.size();
    do_pop  = (sz != 0) && trc_ready;
    do_push = wb_valid && (mode == 0) && ((sz < DEPTH) || do_pop);
    if (wb_valid && mode == 0 && sz == DEPTH && !do_pop) m_ovf = 1;
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      r.pc    = wb_pc;
      r.npc   = wb_next_pc;
      r.instr = wb_instr;
      r.rd    = wb_rd;
      r.we    = (wb_rd == 0) ? 1'b0 : wb_rd_we;
      r.data  = (wb_rd == 0) ? 32'd0 : wb_rd_data;
      q.push_back(r);
      m_rc = m_rc + 1;
    end
    if (mode == 0 && halt) mode = 1;
    else if (mode == 1 && (sz == 0 || (sz == 1 && do_pop))) mode = 2;
  endtask

  task automatic compare();
    check("trc_valid", trc_valid, q.size() != 0);
    check("count", count, q.size());
    check("overflow", overflow, m_ovf);
    check("retire_count", retire_count, m_rc);
    check("drained", drained, mode == 2);
    if (q.size() != 0) begin
      check("trc_pc", trc_pc, q[0].pc);
      check("trc_next_pc", trc_next_pc, q[0].npc);
      check("trc_instr", trc_instr, q[0].instr);
      check("trc_rd", trc_rd, q[0].rd);
      check("trc_rd_we", trc_rd_we, q[0].we);
      check("trc_rd_data", trc_rd_data, q[0].data);
    end else begin
      check("idle_pc", trc_pc, 0);
      check("idle_rd_data", trc_rd_data, 0);
      check("idle_rd_we", trc_rd_we, 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic set_wb(input bit v, input logic [31:0] pc, input logic [4:0] rd,
                        input bit we, input logic [31:0] data);
    wb_valid   = v;
    wb_pc      = pc;
    wb_next_pc = pc + 32'd4;
    wb_instr   = 32'h0000_0013 | (pc << 8);
    wb_rd      = rd;
    wb_rd_we   = we;
    wb_rd_data = data;
  endtask

  task automatic do_reset();
    rst = 1;
    set_wb(1, 32'h0, 5'd3, 1, 32'h1);
    halt = 1;
    trc_ready = 1;
    step();
    rst = 0;
    halt = 0;
    trc_ready = 0;
    set_wb(0, 0, 0, 0, 0);
  endtask

  task automatic fill(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      set_wb(1, base + 32'(i) * 32'd4, 5'd1 + 5'(i), 1, 32'h100 + 32'(i));
      step();
    end
    set_wb(0, 0, 0, 0, 0);
  endtask

  initial begin
    mode = 0; m_ovf = 0; m_rc = 0;
    rst = 1; halt = 0; trc_ready = 0;
    set_wb(0, 0, 0, 0, 0);
    step();
    step();
    rst = 0;
    check("rst_count", count, 0);
    check("rst_valid", trc_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drained", drained, 0);

    // Single push with consumer ready.
    trc_ready = 1;
    set_wb(1, 32'h0, 5'd1, 1, 32'd5);
    wb_instr = 32'h0050_0093;
    step();
    check("first_valid", trc_valid, 1);
    check("first_rd_data", trc_rd_data, 5);
    set_wb(0, 0, 0, 0, 0);
    step();
    check("first_gone", trc_valid, 0);
    check("first_retire", retire_count, 1);

    // x0 write masking.
    trc_ready = 0;
    set_wb(1, 32'h40, 5'd0, 1, 32'hDEAD_BEEF);
    step();
    check("x0_we", trc_rd_we, 0);
    check("x0_data", trc_rd_data, 0);
    set_wb(0, 0, 0, 0, 0);
    trc_ready = 1;
    step();
    trc_ready = 0;

    // Nine pushes into eight slots.
    do_reset();
    fill(9, 32'h0);
    check("ovf_count", count, 8);
    check("ovf_flag", overflow, 1);
    check("ovf_retire", retire_count, 8);
    trc_ready = 1;
    for (int i = 0; i < 8; i++) begin
      check("ovf_order_pc", trc_pc, 32'(i) * 32'd4);
      step();
    end
    check("ovf_sticky", overflow, 1);
    trc_ready = 0;

    // Push and pop together while full.
    do_reset();
    fill(8, 32'h200);
    trc_ready = 1;
    set_wb(1, 32'h100, 5'd7, 1, 32'h77);
    step();
    check("fullpp_count", count, 8);
    check("fullpp_ovf", overflow, 0);
    set_wb(0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step();
    check("fullpp_last_pc", trc_pc, 32'h100);
    step();
    trc_ready = 0;

    // Push and pop together at count==1.
    fill(1, 32'h300);
    trc_ready = 1;
    set_wb(1, 32'h304, 5'd2, 1, 32'h2);
    step();
    check("one_pp_count", count, 1);
    set_wb(0, 0, 0, 0, 0);
    step();
    trc_ready = 0;

    // Halt with a coincident retire, then drain.
    do_reset();
    fill(3, 32'h500);
    set_wb(1, 32'h50C, 5'd4, 1, 32'h4);
    halt = 1;
    step();
    halt = 0;
    check("halt_count", count, 4);
    set_wb(1, 32'h600, 5'd5, 1, 32'h5);
    step();
    check("halt_ignore", count, 4);
    trc_ready = 1;
    for (int i = 0; i < 3; i++) step();
    check("halt_not_drained", drained, 0);
    step();
    check("halt_drained", drained, 1);
    check("halt_ovf", overflow, 0);
    check("halt_retire", retire_count, 4);
    set_wb(0, 0, 0, 0, 0);
    trc_ready = 0;

    // Reset mid-operation with count=5 and overflow set.
    do_reset();
    fill(9, 32'h700);
    trc_ready = 1;
    for (int i = 0; i < 3; i++) step();
    check("pre_rst_count", count, 5);
    check("pre_rst_ovf", overflow, 1);
    do_reset();
    check("post_rst_count", count, 0);
    check("post_rst_valid", trc_valid, 0);
    check("post_rst_ovf", overflow, 0);
    check("post_rst_retire", retire_count, 0);
    set_wb(1, 32'h800, 5'd6, 1, 32'h6);
    step();
    check("post_rst_run", count, 1);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      rst        = ($urandom_range(0, 119) == 0);
      wb_valid   = ($urandom_range(0, 9) < 7);
      wb_pc      = $urandom;
      wb_next_pc = $urandom;
      wb_instr   = $urandom;
      wb_rd      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wb_rd_we   = 1'($urandom_range(0, 1));
      wb_rd_data = $urandom;
      halt       = ($urandom_range(0, 79) == 0);
      trc_ready  = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/retire_trace_buffer.md
RETIRE_TRACE_BUFFER -- requirements
Module: retire_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, minimum 2.
REQ-002 SHALL have parameter XLEN, default 32, datapath width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port wb_valid, input, 1, an instruction retires from WB this cycle.
REQ-006 SHALL have ports wb_pc, wb_next_pc, wb_instr, inputs, XLEN each, retiring PC, following PC, instruction word.
REQ-007 SHALL have ports wb_rd, wb_rd_we, wb_rd_data, inputs, 5/1/XLEN, destination register, write enable, write data.
REQ-008 SHALL have port halt, input, 1, CPU halt pulse.
REQ-009 SHALL have port trc_valid, output, 1, head entry available.
REQ-010 SHALL have port trc_ready, input, 1, consumer accepts head.
REQ-011 SHALL have ports trc_pc, trc_next_pc, trc_instr, trc_rd, trc_rd_we, trc_rd_data, outputs, widths as REQ-006/007, head entry fields.
REQ-012 SHALL have port count, output, $clog2(DEPTH)+1, occupancy.
REQ-013 SHALL have port overflow, output, 1, sticky; an entry was dropped.
REQ-014 SHALL have port retire_count, output, 32, entries accepted since reset.
REQ-015 SHALL have port drained, output, 1, halted and FIFO empty.

Function
REQ-016 Push = wb_valid && state==RUN && (count<DEPTH || pop); pop = trc_valid && trc_ready.
REQ-017 On push, capture all wb_* fields into the tail entry; if wb_rd==0, store rd_we=0 and rd_data=0.
REQ-018 A pushed entry SHALL appear at trc_* exactly one cycle after the push edge (show-ahead head, no extra latency).
REQ-019 trc_valid SHALL equal (count!=0); trc_* SHALL hold stable while trc_valid && !trc_ready.
REQ-020 Simultaneous push and pop SHALL leave count unchanged, including at count==DEPTH and count==1.
REQ-021 wb_valid with count==DEPTH and no pop SHALL drop the entry, set overflow, leave FIFO contents and retire_count unchanged.
REQ-022 overflow SHALL remain 1 until rst.
REQ-023 retire_count SHALL increment by 1 per push, wrapping 0xFFFFFFFF -> 0.
REQ-024 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-025 State machine states: RUN, HALTED, DRAINED.
REQ-026 RUN -> HALTED when halt==1; a wb_valid in the same cycle as halt SHALL still be pushed.
REQ-027 In HALTED and DRAINED, wb_valid SHALL be ignored (no push, no overflow).
REQ-028 HALTED -> DRAINED when count==0, or count==1 with pop; DRAINED is terminal until rst.
REQ-029 drained SHALL be 1 exactly in state DRAINED; pops remain legal in HALTED.

Reset
REQ-030 On rst: state=RUN, pointers=0, count=0, trc_valid=0, overflow=0, retire_count=0, drained=0.
REQ-031 Storage array contents need not be reset; trc_* data outputs SHALL read 0 while count==0.
REQ-032 rst asserted mid-operation SHALL discard all entries in that cycle, regardless of wb_valid/halt/trc_ready.

Structure
REQ-033 A shared package retire_trace_pkg SHALL hold trace_entry_t (pc, next_pc, instr, rd, rd_we, rd_data), the state enum, and default DEPTH/XLEN constants.
REQ-034 Storage and pointer/count logic SHALL be one sub-module trace_fifo (parameterised on DEPTH and trace_entry_t); FSM, x0 masking, overflow and retire counter in the top.

Verification
REQ-035 After rst, push wb_pc=0x0, wb_instr=0x00500093, rd=1, rd_data=5 with trc_ready=1 -> next cycle trc_valid=1, trc_rd_data=5; following cycle trc_valid=0, retire_count=1.
REQ-036 trc_ready=0, push 9 entries pc=0x00..0x20 with DEPTH=8 -> count=8, overflow=1, retire_count=8, then pops return pc 0x00..0x1C in order.
REQ-037 Full FIFO, wb_valid=1 and trc_ready=1 same cycle -> count stays 8, overflow stays 0, new entry is last popped.
REQ-038 Push wb_rd=0, wb_rd_we=1, wb_rd_data=0xDEADBEEF -> trc_rd_we=0, trc_rd_data=0.
REQ-039 3 entries queued, halt=1 with wb_valid=1 -> 4 entries, subsequent wb_valid ignored; drained=1 the cycle after the 4th pop.
REQ-040 rst asserted with count=5 and overflow=1 -> next cycle count=0, trc_valid=0, overflow=0, retire_count=0, state RUN.
